// File: rtl/sd_pkg.sv
// sd_pkg: shared sigma-delta constants and CIC sizing helpers.
package sd_pkg;
  localparam int SD_OSR_DEFAULT = 32;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // sinc3 gain is OSR^3, so one bit per stage per log2(OSR) plus a sign bit
  function automatic int sd_cic_width(input int log2osr);
    return 3 * log2osr + 1;
  endfunction
endpackage

// File: rtl/sd_cic_stage.sv
// sd_cic_stage: one CIC integrator register plus one comb delay register.
module sd_cic_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ev,
  input  logic [WIDTH-1:0] int_in,
  input  logic [WIDTH-1:0] comb_in,
  output logic [WIDTH-1:0] integ,
  output logic [WIDTH-1:0] comb_out
);
  logic [WIDTH-1:0] prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      integ <= '0;
      prev  <= '0;
    end else begin
      if (en) integ <= integ + int_in;
      if (ev) prev <= comb_in;
    end
  assign comb_out = comb_in - prev;
endmodule

// File: rtl/sd_decimator.sv
// sd_decimator: sinc3 decimator turning a 1-bit sigma-delta stream into signed PCM.
// Define SD_DECIM_OVERRUN_EN to expose the sticky overrun flag.
module sd_decimator
  import sd_pkg::*;
#(
  parameter int OSR = SD_OSR_DEFAULT,
  parameter int LOG2_OSR = 5,
  localparam int W = sd_cic_width(LOG2_OSR)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sdIn,
  output logic [W-1:0] out,
  output logic         outValid,
  input  logic         outReady
`ifdef SD_DECIM_OVERRUN_EN
  ,
  output logic         overrun
`endif
);
  localparam logic [W-1:0] HALF = {1'b0, 1'b1, {(3*LOG2_OSR-1){1'b0}}};
  logic [LOG2_OSR-1:0] cnt;
  logic [1:0] settle;
  logic ev, settled, load;
  logic [W-1:0] i1, i2, i3, c1, c2, c3;
  assign ev = en & (&cnt);
  assign settled = &settle;
  assign load = ev & settled;
  sd_cic_stage #(.WIDTH(W)) s1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ev(ev),
    .int_in({{(W-1){1'b0}}, sdIn}), .comb_in(i3), .integ(i1), .comb_out(c1)
  );
  sd_cic_stage #(.WIDTH(W)) s2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ev(ev),
    .int_in(i1), .comb_in(c1), .integ(i2), .comb_out(c2)
  );
  sd_cic_stage #(.WIDTH(W)) s3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ev(ev),
    .int_in(i2), .comb_in(c2), .integ(i3), .comb_out(c3)
  );
  // the first three events still see comb registers primed from zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      settle   <= '0;
      out      <= '0;
      outValid <= 1'b0;
`ifdef SD_DECIM_OVERRUN_EN
      overrun  <= 1'b0;
`endif
    end else begin
      if (en) cnt <= cnt + LOG2_OSR'(1);
      if (ev && !settled) settle <= settle + 2'd1;
      if (load) begin
        out      <= c3 - HALF;
        outValid <= 1'b1;
      end else if (outValid && outReady) outValid <= 1'b0;
`ifdef SD_DECIM_OVERRUN_EN
      if (load && outValid && !outReady) overrun <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_sd_decimator.sv
// tb_sd_decimator: randomized scoreboard bench for sd_decimator against a closed-form sinc3 model.
module tb_sd_decimator;
  localparam int OSR = 32;
  localparam int W = 16;
  localparam longint FULL = longint'(OSR) * OSR * OSR;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sdIn = 1'b0, outReady = 1'b0;
  logic [W-1:0] out;
  logic outValid;
`ifdef SD_DECIM_OVERRUN_EN
  logic overrun;
`endif
  always #5 clk = ~clk;
  sd_decimator #(.OSR(OSR), .LOG2_OSR(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sdIn(sdIn),
    .out(out), .outValid(outValid), .outReady(outReady)
`ifdef SD_DECIM_OVERRUN_EN
    , .overrun(overrun)
`endif
  );
  int checks = 0, failures = 0;
  bit hist[$];
  longint q[$];
  int nev = 0, kind = 0, gap_exp = 0, last_rise = -1, cyc = 0;
  bit exp_ovr = 1'b0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // third-order running sum of the enabled bitstream seen at enabled step t
  function automatic longint s3(input int t);
    longint s = 0;
    for (int j = 0; j < t; j++)
      if (hist[j]) s += longint'(t - 1 - j) * longint'(t - 2 - j) / 2;
    return s;
  endfunction
  function automatic longint model(input int t);
    return s3(t) - 3 * s3(t - OSR) + 3 * s3(t - 2 * OSR) - s3(t - 3 * OSR) - FULL / 2;
  endfunction
  task automatic step(input logic e, input logic b, input logic r);
    bit ev = 1'b0;
    longint v = 0;
    en = e; sdIn = b; outReady = r;
    if (e) begin
      hist.push_back(b);
      if ((hist.size() - 1) % OSR == OSR - 1) begin
        nev++;
        if (nev > 3) begin
          ev = 1'b1;
          v = model(hist.size() - 1);
        end
      end
    end
    @(posedge clk); #1;
    if (ev) q.push_back(v);
  endtask
  task automatic clear_model();
    hist.delete(); q.delete(); nev = 0; exp_ovr = 1'b0;
  endtask
  initial begin : monitor
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (outValid && !pv && gap_exp > 0) begin
        if (last_rise >= 0) chk("event_gap", cyc - last_rise, gap_exp);
        last_rise = cyc;
      end
      pv = outValid;
      if (outValid && outReady) begin
        chk("sample_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          if (q.size() > 1) exp_ovr = 1'b1;
          chk("sample", longint'($signed(out)), q[$]);
          if (kind == 1) chk("dc_pos", longint'($signed(out)), 16384);
          if (kind == 2) chk("dc_neg", longint'($signed(out)), -16384);
          if (kind == 3) chk("alt_within_1lsb", ($signed(out) <= 1 && $signed(out) >= -1), 1);
`ifdef SD_DECIM_OVERRUN_EN
          chk("overrun", overrun, exp_ovr);
`endif
          q.delete();
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end
  initial begin : driver
    int n;
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", out, 0);
    chk("reset_valid", outValid, 0);
`ifdef SD_DECIM_OVERRUN_EN
    chk("reset_overrun", overrun, 0);
`endif
    rst_n = 1'b1;
    repeat (4 * OSR) step(1, 1, 1);
    kind = 1; repeat (6 * OSR) step(1, 1, 1); kind = 0;
    repeat (4 * OSR) step(1, 0, 1);
    kind = 2; repeat (6 * OSR) step(1, 0, 1); kind = 0;
    for (int i = 0; i < 4 * OSR; i++) step(1, i[0], 1);
    kind = 3;
    for (int i = 0; i < 6 * OSR; i++) step(1, i[0], 1);
    kind = 0;
    step(1, 1'b1, 1);
    for (int i = 0; i < 6 * OSR; i++) step(1, i[0], 1);
    gap_exp = 4 * OSR; last_rise = -1;
    repeat (4 * OSR) begin step(1, 1, 1); repeat (3) step(0, 1, 1); end
    kind = 1;
    repeat (4 * OSR) begin step(1, 1, 1); repeat (3) step(0, 1, 1); end
    kind = 0; gap_exp = 0;
    repeat (200) begin step(1, 1'($urandom), 1); if (hist.size() % OSR == 0) break; end
    repeat (3 * OSR) step(1, 1'($urandom), 0);
    chk("hold_valid", outValid, 1);
    chk("hold_latest", longint'($signed(out)), q.size() > 0 ? q[$] : 99999);
`ifdef SD_DECIM_OVERRUN_EN
    chk("hold_overrun", overrun, 1);
`endif
    step(1, 1'($urandom), 1);
    chk("accept_clears_valid", outValid, 0);
    repeat (1500) step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
    repeat (200) begin step(1, 1'($urandom), 1); if (hist.size() % OSR == 17) break; end
    rst_n = 1'b0;
    en = 1'b0;
    clear_model();
    #1;
    chk("async_reset_out", out, 0);
    chk("async_reset_valid", outValid, 0);
`ifdef SD_DECIM_OVERRUN_EN
    chk("async_reset_overrun", overrun, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 6 * OSR && !found; i++) begin
      step(1, 1'($urandom), 1);
      n = i;
      if (outValid) found = 1'b1;
    end
    chk("first_valid_clocks", found ? n : -1, 4 * OSR);
    repeat (4 * OSR) step(1, 1'($urandom), 1);
    repeat (4) step(0, 0, 1);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
